uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
Buffered, parametrised UART transmitter. Integrates a synchronous FIFO and the TX serialiser behind a single valid/ready write port, replacing the hand-built fifo-to-uart_tx_ctrl glue logic. Generalises the fixed 8N1 transmitter with:
- configurable data width, parity and stop bits;
- back-to-back frames with no idle gap;
- a transmit-enable gate for flow control.

Sits between any byte producer (command encoder, debug logger) and the board TX pin.

Parameters:
CLOCK_SPEED, 100_000_000, system clock frequency in Hz.
BAUD, 115200, line rate. CLKS_PER_BIT = CLOCK_SPEED/BAUD (integer truncation); must be >= 4.
DATA_BITS, 8, payload bits per frame. Legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH entries of DATA_BITS each.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_data  in  DATA_BITS  word to transmit.
wr_valid  in  1  producer offers wr_data.
wr_ready  out  1  FIFO can accept; equals !full.
tx_en  in  1  when low, no new frame starts; a frame in flight completes.
uart_tx  out  1  serial line, idle high.
busy  out  1  high while a frame is on the line.
tx_done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.
count  out  ADDR_WIDTH+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - uart_tx=1, busy=0, tx_done=0, count=0, wr_ready=1.
  - FIFO pointers cleared; FSM in IDLE; baud counter 0.
  - Reset mid-frame aborts the frame: uart_tx goes high immediately and FIFO contents are discarded.
- Write:
  - Word accepted on an edge where wr_valid && wr_ready.
  - count increments after that edge.
  - When full, wr_valid is ignored and no data is corrupted.
- Simultaneous accept and pop on the same edge: count unchanged and pointers both advance.
- Pointers wrap modulo depth. full = (count == depth), empty = (count == 0).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On an edge with tx_en && !empty: pop head into shift register, uart_tx<=0, busy<=1, state<=START, baud counter cleared.
  - Latency: a write accepted at edge N into an empty FIFO with the FSM idle gives uart_tx low after edge N+1.
- Bit timing: every bit lasts exactly CLKS_PER_BIT cycles.
- DATA:
  - DATA_BITS bits, LSB first.
  - Shift register shifts right once per bit period.
- PARITY (skipped when PARITY=0):
  - even: bit = XOR of data bits.
  - odd: bit = inverted XOR of data bits.
  - Parity is computed at pop time.
- STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done pulses on the final cycle.
- End of STOP:
  - If tx_en && !empty: pop next word and enter START directly; zero idle cycles between frames, busy stays 1.
  - Otherwise: IDLE, busy<=0.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_en deasserted mid-frame: current frame finishes unchanged, then the FSM holds in IDLE with the FIFO retained. Writes continue to be accepted.
- uart_tx is driven from a register; no combinational path from any input.

Test Plan:
1. CLOCK_SPEED=100e6, BAUD=400000 (250 clks/bit), 8N1: write 8'h61 → uart_tx low one cycle after accept edge; bits 1,0,0,0,0,1,1,0 each 250 cycles; stop high 250 cycles; tx_done single pulse at cycle 2500; busy low afterwards.
2. Burst of 0x01..0x16 (22 words) with ADDR_WIDTH=4:
   - wr_ready drops when count=16 and reasserts after the first pop;
   - a loopback uart_rx_ctrl receives all 22 values in order;
   - exactly 2500-cycle spacing between start-bit falling edges (no gaps).
3. DATA_BITS=7, PARITY=2 (even), STOP_BITS=2, write 7'h53:
   - parity bit=0;
   - frame 11 bits = 2750 cycles;
   - repeat with PARITY=1 → parity bit=1.
4. tx_en dropped mid-frame with 3 words queued:
   - current frame completes;
   - line stays high; count=3 held;
   - re-assert tx_en → next frame starts after one edge.
5. rst_n pulsed low in DATA state with count=5:
   - uart_tx=1 and busy=0 asynchronously;
   - count=0 and wr_ready=1 after release;
   - no tx_done pulse.
6. Write into full FIFO while a pop occurs on the same edge: write is rejected (wr_ready was 0), count goes 16→15, no overwrite of unsent data.

Source files
------------

// File: rtl/uart_tx_buffered.sv
`timescale 1ns/1ps
// uart_tx_buffered: FIFO-fed UART transmitter with configurable frame format.
// A single valid/ready write port fills a 2**ADDR_WIDTH-deep FIFO; the
// serialiser pops the head whenever tx_en is high and sends frames
// back-to-back with no idle gap between them.
module uart_tx_buffered #(
  parameter int CLOCK_SPEED = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS   = 1,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 tx_en,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [ADDR_WIDTH:0]  count
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CLKS);
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam int DEPTH        = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  // Reject parameter sets the bit timing and frame logic cannot support.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_tx_buffered: CLOCK_SPEED/BAUD must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_buffered: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Reset conditioning: assertion is immediate, release waits two edges so
  // every flop below leaves reset on the same clock.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  // Shift a one into the synchroniser once rst_n is released.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Synchroniser flops, cleared asynchronously by the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full, empty, push, pop;
  logic [DATA_BITS-1:0]  head;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push     = wr_valid && !full;
  assign wr_ready = !full;
  assign count    = count_q;
  // Head is read combinationally so a word written on one edge can be
  // popped into the shift register on the very next edge.
  assign head     = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a push and pop together leave count alone.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end, stop_end, can_start, head_par;

  assign bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign stop_end  = (cnt_q == CNT_W'(STOP_CLKS - 1));
  assign can_start = tx_en && !empty;
  // Even parity is the XOR of the payload; odd parity is its complement.
  assign head_par  = (PARITY == 1) ? ~(^head) : (^head);

  // Next-state logic: one bit period per CLKS_PER_BIT cycles, chained frames.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (stop_end) begin
          cnt_d = '0;
          if (can_start) begin
            // Chain straight into the next start bit; busy never drops.
            pop     = 1'b1;
            shift_d = head;
            par_d   = head_par;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Serialiser state register; reset drives the line idle immediately.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign tx_done = (state_q == ST_STOP) && stop_end;

endmodule

// File: tb/tb_uart_tx_buffered.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_buffered: an 8N1 instance plus 7E2 and 7O2
// instances sharing one clock and reset.
module tb_uart_tx_buffered;

  localparam int CPB = 250;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // 8N1 instance
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready, tx_en, uart_tx, busy, tx_done;
  logic [4:0] count;

  uart_tx_buffered #(
    .CLOCK_SPEED(100_000_000), .BAUD(400_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .tx_en(tx_en), .uart_tx(uart_tx), .busy(busy),
    .tx_done(tx_done), .count(count)
  );

  // 7E2 instance
  logic [6:0] wr_data_e;
  logic       wr_valid_e, wr_ready_e, tx_en_e, uart_tx_e, busy_e, tx_done_e;
  logic [4:0] count_e;

  uart_tx_buffered #(
    .CLOCK_SPEED(100_000_000), .BAUD(400_000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .ADDR_WIDTH(4)
  ) dut_e (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data_e), .wr_valid(wr_valid_e),
    .wr_ready(wr_ready_e), .tx_en(tx_en_e), .uart_tx(uart_tx_e), .busy(busy_e),
    .tx_done(tx_done_e), .count(count_e)
  );

  // 7O2 instance
  logic [6:0] wr_data_o;
  logic       wr_valid_o, wr_ready_o, tx_en_o, uart_tx_o, busy_o, tx_done_o;
  logic [4:0] count_o;

  uart_tx_buffered #(
    .CLOCK_SPEED(100_000_000), .BAUD(400_000), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .ADDR_WIDTH(4)
  ) dut_o (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data_o), .wr_valid(wr_valid_o),
    .wr_ready(wr_ready_o), .tx_en(tx_en_o), .uart_tx(uart_tx_o), .busy(busy_o),
    .tx_done(tx_done_o), .count(count_o)
  );

  // Loopback receiver on the 8N1 line: samples bit centres, records
  // {stop, data} and the cycle at which each start edge was seen.
  logic [8:0] rx_q [$];
  int         rx_t [$];
  logic       rx_prev = 1'b1;
  logic [8:0] rx_v;
  int         rx_t0;
  always begin
    @(negedge clk);
    if (rx_prev === 1'b1 && uart_tx === 1'b0) begin
      rx_t0 = cyc;
      repeat (CPB / 2 - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_v[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      rx_v[8] = uart_tx;
      rx_q.push_back(rx_v);
      rx_t.push_back(rx_t0);
      rx_prev = uart_tx;
    end else begin
      rx_prev = uart_tx;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (uart_tx !== 1'b1)  begin n_fail++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (tx_done !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
    n_checks++; if (count !== 5'd0)    begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_checks++; if (uart_tx_e !== 1'b1 || uart_tx_o !== 1'b1 || count_e !== 5'd0 || count_o !== 5'd0) begin
      n_fail++; $display("FAIL reset_7bit tx_e=%b tx_o=%b cnt_e=%0d cnt_o=%0d want 1 1 0 0", uart_tx_e, uart_tx_o, count_e, count_o);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    logic [9:0] bad;
    int done_cnt, done_at, bb;
    logic busy_bad;
    frame = {1'b1, 8'h61, 1'b0};
    bad = '0; done_cnt = 0; done_at = -1; busy_bad = 1'b0;
    @(negedge clk); wr_data = 8'h61; wr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); wr_valid = 1'b0;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_latency_high got %b want 1", uart_tx); end
    for (int s = 1; s <= 10 * CPB; s++) begin
      @(negedge clk);
      bb = (s - 1) / CPB;
      if (uart_tx !== frame[bb]) bad[bb] = 1'b1;
      if (tx_done === 1'b1) begin done_cnt++; done_at = s; end
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    for (int b = 0; b < 10; b++) begin
      n_checks++; if (bad[b]) begin n_fail++; $display("FAIL single_bit%0d line wrong within bit, want %b", b, frame[b]); end
    end
    n_checks++; if (done_cnt !== 1 || done_at !== 2500) begin
      n_fail++; $display("FAIL single_tx_done pulses=%0d at=%0d want 1 at 2500", done_cnt, done_at);
    end
    n_checks++; if (busy_bad) begin n_fail++; $display("FAIL single_busy dropped during frame, want 1"); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || uart_tx !== 1'b1 || count !== 5'd0) begin
      n_fail++; $display("FAIL single_after busy=%b tx=%b count=%0d want 0 1 0", busy, uart_tx, count);
    end
    $display("single_frame: 0x61 sent, tx_done at %0d", done_at);
  endtask

  task automatic test_parity_frames();
    logic [10:0] fe, fo, bad_e, bad_o;
    int de, de_at, dq, dq_at, bb;
    fe = {2'b11, 1'b0, 7'h53, 1'b0};
    fo = {2'b11, 1'b1, 7'h53, 1'b0};
    bad_e = '0; bad_o = '0; de = 0; dq = 0; de_at = -1; dq_at = -1;
    @(negedge clk);
    wr_data_e = 7'h53; wr_valid_e = 1'b1;
    wr_data_o = 7'h53; wr_valid_o = 1'b1;
    @(posedge clk);
    @(negedge clk); wr_valid_e = 1'b0; wr_valid_o = 1'b0;
    for (int s = 1; s <= 11 * CPB; s++) begin
      @(negedge clk);
      bb = (s - 1) / CPB;
      if (uart_tx_e !== fe[bb]) bad_e[bb] = 1'b1;
      if (uart_tx_o !== fo[bb]) bad_o[bb] = 1'b1;
      if (tx_done_e === 1'b1) begin de++; de_at = s; end
      if (tx_done_o === 1'b1) begin dq++; dq_at = s; end
    end
    n_checks++; if (bad_e[8]) begin n_fail++; $display("FAIL even_parity_bit line wrong, want 0"); end
    n_checks++; if (bad_o[8]) begin n_fail++; $display("FAIL odd_parity_bit line wrong, want 1"); end
    n_checks++; if (bad_e !== 11'd0) begin n_fail++; $display("FAIL even_frame bad bit mask %b want 0", bad_e); end
    n_checks++; if (bad_o !== 11'd0) begin n_fail++; $display("FAIL odd_frame bad bit mask %b want 0", bad_o); end
    n_checks++; if (de !== 1 || de_at !== 2750) begin n_fail++; $display("FAIL even_tx_done pulses=%0d at=%0d want 1 at 2750", de, de_at); end
    n_checks++; if (dq !== 1 || dq_at !== 2750) begin n_fail++; $display("FAIL odd_tx_done pulses=%0d at=%0d want 1 at 2750", dq, dq_at); end
    @(negedge clk);
    n_checks++; if (busy_e !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL parity_after busy_e=%b busy_o=%b want 0 0", busy_e, busy_o); end
    $display("parity_frames: 7E2 and 7O2 of 0x53 sent, done at %0d/%0d", de_at, dq_at);
  endtask

  task automatic test_back_to_back();
    int idx, prev_count;
    logic rdy, full_seen, full_ready_bad, released;
    idx = 0; full_seen = 1'b0; full_ready_bad = 1'b0; released = 1'b0;
    rx_q.delete(); rx_t.delete();
    tx_en = 1'b1;
    prev_count = count;
    for (int c = 0; c < 30000 && idx < 22; c++) begin
      @(negedge clk);
      if (count === 5'd16) begin
        full_seen = 1'b1;
        if (wr_ready !== 1'b0) full_ready_bad = 1'b1;
      end
      if (!released && prev_count == 16 && count !== 5'd16) begin
        released = 1'b1;
        n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL full_pop_count got %0d want 15", count); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready got %b want 1", wr_ready); end
      end
      prev_count = count;
      wr_data = 8'(idx + 1); wr_valid = 1'b1; rdy = wr_ready;
      @(posedge clk);
      if (rdy) idx++;
    end
    @(negedge clk); wr_valid = 1'b0;
    n_checks++; if (idx !== 22) begin n_fail++; $display("FAIL burst_accepted got %0d want 22", idx); end
    n_checks++; if (!full_seen || full_ready_bad || !released) begin
      n_fail++; $display("FAIL burst_full seen=%b ready_when_full=%b released=%b want 1 0 1", full_seen, full_ready_bad, released);
    end
    for (int c = 0; c < 60000 && rx_q.size() < 22; c++) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 22) begin
      n_fail++; $display("FAIL burst_rx_count got %0d want 22", rx_q.size());
    end else begin
      for (int i = 0; i < 22; i++) begin
        n_checks++; if (rx_q[i] !== {1'b1, 8'(i + 1)}) begin
          n_fail++; $display("FAIL burst_rx[%0d] got %h want %h", i, rx_q[i], {1'b1, 8'(i + 1)});
        end
      end
      for (int i = 1; i < 22; i++) begin
        n_checks++; if (rx_t[i] - rx_t[i-1] !== 2500) begin
          n_fail++; $display("FAIL burst_spacing[%0d] got %0d want 2500", i, rx_t[i] - rx_t[i-1]);
        end
      end
    end
    $display("back_to_back: %0d words received", rx_q.size());
  endtask

  task automatic test_tx_en_gate();
    int s;
    logic found, hold_bad;
    tx_en = 1'b0;
    repeat (200) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gate_idle busy=%b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hA0 + 8'(i); wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    n_checks++; if (count !== 5'd4 || uart_tx !== 1'b1) begin n_fail++; $display("FAIL gate_queued count=%0d tx=%b want 4 1", count, uart_tx); end
    rx_q.delete(); rx_t.delete();
    tx_en = 1'b1;
    @(negedge clk);
    s = 1;
    n_checks++; if (count !== 5'd3 || uart_tx !== 1'b0) begin n_fail++; $display("FAIL gate_first_pop count=%0d tx=%b want 3 0", count, uart_tx); end
    repeat (500) begin @(negedge clk); s++; end
    tx_en = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); s++;
      if (tx_done === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++; if (!found || s !== 2500) begin n_fail++; $display("FAIL gate_frame_end found=%b at=%0d want 1 at 2500", found, s); end
    hold_bad = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || count !== 5'd3) hold_bad = 1'b1;
    end
    n_checks++; if (hold_bad) begin n_fail++; $display("FAIL gate_hold line/busy/count moved while gated, want 1/0/3"); end
    n_checks++;
    if (rx_q.size() != 1) begin n_fail++; $display("FAIL gate_rx_count got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 9'h1A0) begin n_fail++; $display("FAIL gate_rx_data got %h want 1a0", rx_q[0]); end
    tx_en = 1'b1;
    @(negedge clk);
    n_checks++; if (uart_tx !== 1'b0 || busy !== 1'b1 || count !== 5'd2) begin
      n_fail++; $display("FAIL gate_restart tx=%b busy=%b count=%0d want 0 1 2", uart_tx, busy, count);
    end
    $display("tx_en_gate: frame completed, held, restarted");
  endtask

  task automatic test_reset_mid_frame();
    logic done_seen, line_bad;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'hB0 + 8'(i); wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (400) @(negedge clk);
    n_checks++; if (count !== 5'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre count=%0d busy=%b want 5 1", count, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async tx=%b busy=%b want 1 0", uart_tx, busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL midrst_async_done got %b want 0", tx_done); end
    done_seen = 1'b0; line_bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen = 1'b1;
      if (uart_tx !== 1'b1) line_bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (count !== 5'd0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release count=%0d ready=%b want 0 1", count, wr_ready); end
    for (int k = 0; k < 2600; k++) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen = 1'b1;
      if (uart_tx !== 1'b1 || busy !== 1'b0) line_bad = 1'b1;
    end
    n_checks++; if (done_seen) begin n_fail++; $display("FAIL midrst_no_done got pulse want none"); end
    n_checks++; if (line_bad) begin n_fail++; $display("FAIL midrst_line line low or busy after reset, want idle"); end
    $display("reset_mid_frame: aborted frame, FIFO cleared");
  endtask

  initial begin
    rst_n = 1'b0;
    wr_data = '0; wr_valid = 1'b0; tx_en = 1'b1;
    wr_data_e = '0; wr_valid_e = 1'b0; tx_en_e = 1'b1;
    wr_data_o = '0; wr_valid_o = 1'b0; tx_en_o = 1'b1;
    test_reset();
    test_single_frame();
    test_parity_frames();
    test_back_to_back();
    test_tx_en_gate();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
